// File: rtl/password_entry_if.sv
// password_entry_if: keypad-side inputs and access-control-side outputs of password_entry.
interface password_entry_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4
);
  logic [DIGIT_W-1:0]              digit_in;
  logic                            digit_enter;
  logic                            submit;
  logic                            clear;
  logic [1:0]                      req_sel;
  logic [NUM_DIGITS*DIGIT_W-1:0]   data_out;
  logic                            data_load;
  logic [1:0]                      request;
  logic [$clog2(NUM_DIGITS+1)-1:0] digit_count;
  logic                            entry_err;
  modport master (
    output digit_in, digit_enter, submit, clear, req_sel,
    input  data_out, data_load, request, digit_count, entry_err
  );
  modport slave (
    input  digit_in, digit_enter, submit, clear, req_sel,
    output data_out, data_load, request, digit_count, entry_err
  );
endinterface

// File: rtl/password_entry.sv
// password_entry: assembles keypad digits into a password word and strobes it to access control.
module password_entry #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic             clk,
  input logic             rst,
  password_entry_if.slave bus
);
  localparam int DATA_W = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {IDLE, COLLECT, FULL, LOAD} state_t;
  state_t             r_state, w_next;
  logic [DATA_W-1:0]  r_data;
  logic [1:0]         r_req;
  logic [CNT_W-1:0]   r_cnt, w_cnt_inc;
  logic [TMR_W-1:0]   r_tmr;
  logic               r_err;
  logic               w_active, w_take, w_accept, w_reject, w_quiet, w_expire;
  // A digit arriving with submit while collecting wins silently, so submit is only rejected alone.
  always_comb begin
    w_active  = r_state == COLLECT || r_state == FULL;
    w_take    = bus.digit_enter && (r_state == IDLE || r_state == COLLECT);
    w_accept  = bus.submit && r_state == FULL;
    w_reject  = bus.submit && !bus.digit_enter && (r_state == IDLE || r_state == COLLECT);
    w_quiet   = w_active && !bus.digit_enter && !bus.submit;
    w_expire  = w_quiet && r_tmr == TMR_W'(TIMEOUT_CYCLES - 1);
    w_cnt_inc = r_state == IDLE ? CNT_W'(1) : r_cnt + CNT_W'(1);
  end
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb
    w_next = (bus.clear || w_expire || r_state == LOAD) ? IDLE :
             w_take   ? (w_cnt_inc == CNT_W'(NUM_DIGITS) ? FULL : COLLECT) :
             w_accept ? LOAD : r_state;
  always_comb begin
    bus.data_load   = r_state == LOAD;
    bus.data_out    = r_data;
    bus.request     = r_req;
    bus.digit_count = r_cnt;
    bus.entry_err   = r_err;
  end
  // Data and request survive the load so a slow downstream stage can still sample them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_req  <= '0;
      r_cnt  <= '0;
      r_tmr  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= !bus.clear && (w_reject || w_expire);
      r_tmr <= (w_quiet && !w_expire && !bus.clear) ? r_tmr + TMR_W'(1) : '0;
      if (bus.clear || w_expire) begin
        r_data <= '0;
        r_cnt  <= '0;
      end else if (w_take) begin
        r_data <= r_state == IDLE ? DATA_W'(bus.digit_in) : {r_data[DATA_W-DIGIT_W-1:0], bus.digit_in};
        r_cnt  <= w_cnt_inc;
      end else if (r_state == LOAD) begin
        r_cnt  <= '0;
      end
      if (bus.clear)
        r_req <= '0;
      else if (w_accept)
        r_req <= bus.req_sel;
    end
  end
endmodule

// File: tb/tb_password_entry.sv
// tb_password_entry: random and directed stimulus against a digit-queue reference model with an event scoreboard.
module tb_password_entry;
  localparam int N = 4;
  localparam int T = 16;
  typedef struct {
    int         cyc;
    bit         ld;
    logic [15:0] d;
    logic [1:0] rq;
    int         cnt;
  } ev_t;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   started = 0;
  int   n_vec = 0;
  int   n_err = 0;
  ev_t  sb_q[$];
  int   digs[$];
  logic [15:0] m_data;
  logic [1:0]  m_req;
  bit   m_load;
  int   m_idle;
  password_entry_if #(.NUM_DIGITS(N), .DIGIT_W(4)) bus ();
  password_entry #(.NUM_DIGITS(N), .DIGIT_W(4), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic push_ev(input bit ld);
    ev_t e;
    e.cyc = cyc + 1;
    e.ld  = ld;
    e.d   = m_data;
    e.rq  = m_req;
    e.cnt = ld ? N : digs.size();
    sb_q.push_back(e);
  endtask
  task automatic refold();
    m_data = '0;
    foreach (digs[i]) m_data = m_data * 16 + 16'(digs[i]);
  endtask
  task automatic model_step(input logic [3:0] d, input bit de, input bit sb, input bit cl,
                            input logic [1:0] rq, input bit r);
    if (r) begin
      digs.delete(); m_data = '0; m_req = '0; m_load = 0; m_idle = 0;
    end else if (m_load) begin
      m_load = 0; digs.delete();
      if (cl) begin m_data = '0; m_req = '0; end
    end else if (cl) begin
      digs.delete(); m_data = '0; m_req = '0; m_idle = 0;
    end else if (digs.size() == N && sb) begin
      m_req = rq; m_load = 1; m_idle = 0; push_ev(1);
    end else if (digs.size() < N && de) begin
      digs.push_back(int'(d)); refold(); m_idle = 0;
    end else if (digs.size() < N && sb) begin
      m_idle = 0; push_ev(0);
    end else if (digs.size() > 0) begin
      if (de) m_idle = 0;
      else if (m_idle == T - 1) begin
        digs.delete(); m_data = '0; m_idle = 0; push_ev(0);
      end else m_idle++;
    end
  endtask
  task automatic check_state();
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      n_vec++; n_err++;
      $display("FAIL missed_event: got none expected %s at cycle %0d", sb_q[0].ld ? "load" : "err", sb_q[0].cyc);
      void'(sb_q.pop_front());
    end
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("digit_count", 32'(bus.digit_count), m_load ? N : digs.size());
    chk("request", 32'(bus.request), 32'(m_req));
  endtask
  task automatic tick(input logic [3:0] d, input bit de, input bit sb, input bit cl,
                      input logic [1:0] rq, input bit r);
    check_state();
    bus.digit_in = d; bus.digit_enter = de; bus.submit = sb; bus.clear = cl;
    bus.req_sel = rq; rst = r;
    model_step(d, de, sb, cl, rq, r);
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(4'h0, 0, 0, 0, 2'b00, 0);
  endtask
  task automatic digit(input logic [3:0] v);
    tick(v, 1, 0, 0, 2'b00, 0);
  endtask
  always @(negedge clk) begin
    ev_t e;
    if (started && (bus.data_load || bus.entry_err)) begin
      if (sb_q.size() == 0) chk("unexpected_event", 32'({bus.data_load, bus.entry_err}), 32'd0);
      else begin
        e = sb_q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ev_kind", 32'({bus.data_load, bus.entry_err}), e.ld ? 32'd2 : 32'd1);
        chk("ev_data", 32'(bus.data_out), 32'(e.d));
        chk("ev_count", 32'(bus.digit_count), e.cnt);
        if (e.ld) chk("ev_request", 32'(bus.request), 32'(e.rq));
      end
    end
  end
  initial begin
    rst = 1'b1;
    bus.digit_in = '0; bus.digit_enter = 0; bus.submit = 0; bus.clear = 0; bus.req_sel = '0;
    model_step(4'h0, 0, 0, 0, 2'b00, 1);
    @(posedge clk); #1;
    started = 1;
    tick(4'h0, 0, 0, 0, 2'b00, 1);
    chk("reset_data", 32'(bus.data_out), 32'd0);
    chk("reset_load", 32'(bus.data_load), 32'd0);
    // 1: full entry and submit
    digit(4'h1); digit(4'h2); digit(4'h3); digit(4'h4);
    tick(4'h0, 0, 1, 0, 2'b01, 0);
    chk("t1_load", 32'(bus.data_load), 32'd1);
    chk("t1_data", 32'(bus.data_out), 32'h1234);
    chk("t1_request", 32'(bus.request), 32'd1);
    idle(1);
    chk("t1_count_after", 32'(bus.digit_count), 32'd0);
    // 2: early submit is rejected
    digit(4'h9); digit(4'h8);
    tick(4'h0, 0, 1, 0, 2'b10, 0);
    chk("t2_err", 32'(bus.entry_err), 32'd1);
    chk("t2_data", 32'(bus.data_out), 32'h0098);
    chk("t2_count", 32'(bus.digit_count), 32'd2);
    tick(4'h0, 0, 0, 1, 2'b00, 0);
    // 3: fifth digit dropped while full
    digit(4'hA); digit(4'hB); digit(4'hC); digit(4'hD); digit(4'hE);
    chk("t3_no_err", 32'(bus.entry_err), 32'd0);
    tick(4'h0, 0, 1, 0, 2'b11, 0);
    chk("t3_data", 32'(bus.data_out), 32'hABCD);
    idle(1);
    // 4: timeout discards the partial entry
    digit(4'h5);
    idle(T);
    chk("t4_err", 32'(bus.entry_err), 32'd1);
    chk("t4_data", 32'(bus.data_out), 32'd0);
    chk("t4_count", 32'(bus.digit_count), 32'd0);
    // 5: clear beats a simultaneous digit
    digit(4'h1); digit(4'h2); digit(4'h3);
    tick(4'h4, 1, 0, 1, 2'b00, 0);
    chk("t5_data", 32'(bus.data_out), 32'd0);
    chk("t5_count", 32'(bus.digit_count), 32'd0);
    chk("t5_err", 32'(bus.entry_err), 32'd0);
    // 6: reset during the load cycle
    digit(4'h6); digit(4'h7); digit(4'h8); digit(4'h9);
    tick(4'h0, 0, 1, 0, 2'b10, 0);
    tick(4'h0, 0, 0, 0, 2'b00, 1);
    chk("t6_load", 32'(bus.data_load), 32'd0);
    chk("t6_data", 32'(bus.data_out), 32'd0);
    chk("t6_request", 32'(bus.request), 32'd0);
    for (int k = 0; k < 3000; k++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) tick(4'h0, 0, 0, 0, 2'b00, 1);
      else if (r < 10) idle(int'($urandom_range(14, 18)));
      else tick(4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 40) == 0, 2'($urandom_range(0, 3)), 0);
    end
    idle(3);
    chk("queue_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
